// File: rtl/rr_pkg.sv
// Shared constants and grant-decoding helpers for the round-robin arbiter
// and its request/dispatch front end.
//   NPORT          : number of requester ports
//   PORT_W         : width of a port index
//   is_onehot4     : 1 when exactly one bit of a 4-bit vector is set
//   onehot4_to_idx : index of the set bit of a one-hot 4-bit vector
package rr_pkg;

  localparam int unsigned NPORT  = 4;
  localparam int unsigned PORT_W = 2;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for one-hot inputs; returns the highest set bit otherwise.
  function automatic logic [PORT_W-1:0] onehot4_to_idx(input logic [3:0] v);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (v[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head read-out by pointer.
// The caller guarantees push only when not full and pop only when not empty.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count)
//   push       : write push_data at the tail this edge
//   push_data  : word to write
//   pop        : advance the head this edge
//   head       : word at the head (valid while count != 0)
//   count      : number of stored words, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rr_req_dispatch.sv
// Four-port request buffer and grant consumer for the 4-bit round-robin
// arbiter. Each port queues words in its own FIFO; FIFO occupancy drives the
// arbiter requests, and the arbiter's registered grant pops the granted FIFO
// into a single valid/ready output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-port push request
//   in_data    : port i word at [i*DW +: DW]
//   in_ready   : per-port FIFO not full (combinational from counts)
//   req        : request vector to the arbiter (combinational)
//   gnt        : registered grant vector from the arbiter
//   out_valid  : output register holds a word
//   out_data   : dispatched word
//   out_src    : source port of out_data
//   out_ready  : downstream accepts the output word
//   gnt_err    : sticky, set when gnt was non-zero and not one-hot
module rr_req_dispatch
  import rr_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORT-1:0]      in_valid,
  input  logic [NPORT*DW-1:0]   in_data,
  output logic [NPORT-1:0]      in_ready,
  output logic [NPORT-1:0]      req,
  input  logic [NPORT-1:0]      gnt,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic [PORT_W-1:0]     out_src,
  input  logic                  out_ready,
  output logic                  gnt_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     cnt  [NPORT];
  logic [DW-1:0]     head [NPORT];
  logic [NPORT-1:0]  push;
  logic [NPORT-1:0]  pop;
  logic              gnt_ok;
  logic              gnt_bad;
  logic [PORT_W-1:0] gidx;
  logic              load;

  // Grant qualification and load decision.
  always_comb begin
    gnt_ok  = is_onehot4(gnt);
    gnt_bad = (gnt != '0) && !gnt_ok;
    gidx    = onehot4_to_idx(gnt);
    // A grant to an empty queue or while the output is stalled is dropped.
    load    = gnt_ok && (cnt[gidx] != '0) && (!out_valid || out_ready);
  end

  // Per-port ready, push, pop and request.
  always_comb begin
    in_ready = '0;
    push     = '0;
    pop      = '0;
    req      = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      in_ready[i] = (cnt[i] != CW'(DEPTH));
      push[i]     = in_valid[i] && in_ready[i];
      pop[i]      = load && (gidx == PORT_W'(i));
      // A queue draining its last word drops req now so it is not re-granted.
      req[i]      = cnt[i] > (pop[i] ? CW'(1) : CW'(0));
    end
  end

  // Per-port FIFOs.
  for (genvar g = 0; g < NPORT; g++) begin : g_fifo
    sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[g]),
      .push_data (in_data[g*DW +: DW]),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (cnt[g])
    );
  end

  // Output register: load wins over drain so back-to-back words stay valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= head[gidx];
      out_src   <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky malformed-grant flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_err <= 1'b0;
    end else if (gnt_bad) begin
      gnt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_req_dispatch.sv
// Bench for rr_req_dispatch: queue-based reference model, directed vector
// table, multi-cycle corner sequences and randomized traffic.
module tb_rr_req_dispatch;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic [3:0]    req;
  logic [3:0]    gnt;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_ready;
  logic          gnt_err;

  always #5 clk = ~clk;

  rr_req_dispatch #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .gnt_err   (gnt_err)
  );

  int errs   = 0;
  int checks = 0;

  // Reference model: one queue per port plus the expected output register.
  logic [DW-1:0] mq [4][$];
  logic          m_ov;
  logic [DW-1:0] m_od;
  logic [1:0]    m_os;
  logic          m_err;

  // Round-robin arbiter stand-in (registered grant).
  logic       arb_on;
  int         arb_last;
  logic [3:0] req_s;

  typedef struct {
    logic [3:0]      v;
    logic [4*DW-1:0] d;
    logic            ordy;
    logic [3:0]      g;
    logic [3:0]      e_req;
    logic [3:0]      e_rdy;
    logic            e_ov;
    logic [DW-1:0]   e_od;
    logic [1:0]      e_os;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = '0;
    m_err = 1'b0;
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear immediately.
  task automatic do_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    gnt       = '0;
    arb_on    = 1'b0;
    arb_last  = 0;
    rst_n     = 1'b0;
    #1;
    model_clear();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req",       32'(req),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'hf);
    chk("rst_gnt_err",   32'(gnt_err),   32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs after an edge, check combinational outputs at
  // mid-cycle, step the model at the edge, then check registered outputs.
  task automatic cycle(input logic [3:0] v, input logic [4*DW-1:0] d,
                       input logic ordy, input logic [3:0] g,
                       output logic [3:0] req_mid, output logic [3:0] rdy_mid);
    int         gi;
    logic       oh;
    logic       ld;
    logic [3:0] er;
    logic [3:0] ey;
    logic [3:0] acc;
    logic       found;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    if (!arb_on) gnt = g;
    #4;
    oh = ($countones(gnt) == 1);
    gi = 0;
    for (int i = 0; i < 4; i++) if (gnt[i]) gi = i;
    ld = oh && (mq[gi].size() > 0) && (!m_ov || ordy);
    for (int i = 0; i < 4; i++) begin
      er[i]  = mq[i].size() > ((ld && gi == i) ? 1 : 0);
      ey[i]  = mq[i].size() != DEPTH;
      acc[i] = v[i] && ey[i];
    end
    chk("req", 32'(req), 32'(er));
    chk("in_ready", 32'(in_ready), 32'(ey));
    req_mid = req;
    rdy_mid = in_ready;
    req_s   = req;
    @(posedge clk);
    #1;
    if (ld) begin
      m_od = mq[gi].pop_front();
      m_os = gi[1:0];
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(d[i*DW +: DW]);
    if (gnt != 4'd0 && !oh) m_err = 1'b1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_src",  32'(out_src),  32'(m_os));
    end
    chk("gnt_err", 32'(gnt_err), 32'(m_err));
    if (arb_on) begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (arb_last + k) % 4;
        if (!found && req_s[idx]) begin
          gnt      = 4'(1 << idx);
          arb_last = idx;
          found    = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vec_t          vec [9];
    logic [3:0]    rq;
    logic [3:0]    ry;
    logic [DW-1:0] hold_d;
    logic [1:0]    hold_s;
    int            nout;
    int            src_q [$];
    int            cyc_q [$];
    int            exp_src [8];
    logic [3:0]    g;
    int            r;

    // Single word on port 2, backpressure on a stalled output, empty grant.
    vec[0] = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0};
    vec[1] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0100, 4'b1111, 1'b0, 8'h00, 2'd0};
    vec[2] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0100, 4'b0000, 4'b1111, 1'b1, 8'hA5, 2'd2};
    vec[3] = '{4'b1010, 32'h3C00_1E00, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1, 8'hA5, 2'd2};
    vec[4] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b1000, 4'b1010, 4'b1111, 1'b1, 8'hA5, 2'd2};
    vec[5] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b1000, 4'b0010, 4'b1111, 1'b1, 8'h3C, 2'd3};
    vec[6] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0001, 4'b0010, 4'b1111, 1'b0, 8'h00, 2'd0};
    vec[7] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0010, 4'b0000, 4'b1111, 1'b1, 8'h1E, 2'd1};
    vec[8] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0};
    exp_src = '{1, 2, 3, 0, 1, 2, 3, 0};

    rst_n     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    gnt       = '0;
    arb_on    = 1'b0;
    arb_last  = 0;
    #2;
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      cycle(vec[i].v, vec[i].d, vec[i].ordy, vec[i].g, rq, ry);
      chk($sformatf("vec%0d_req", i), 32'(rq), 32'(vec[i].e_req));
      chk($sformatf("vec%0d_rdy", i), 32'(ry), 32'(vec[i].e_rdy));
      chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vec[i].e_ov));
      if (vec[i].e_ov) begin
        chk($sformatf("vec%0d_od", i), 32'(out_data), 32'(vec[i].e_od));
        chk($sformatf("vec%0d_os", i), 32'(out_src),  32'(vec[i].e_os));
      end
    end

    // Fill port 0 with no grants; the fifth push must be refused.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0001, 32'(8'h10 + k), 1'b1, 4'b0000, rq, ry);
      if (k == 3) chk("fill_ready_low", 32'(in_ready[0]), 32'd0);
    end
    chk("fill_ready_still_low", 32'(in_ready[0]), 32'd0);
    nout = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(4'b0000, '0, 1'b1, 4'b0001, rq, ry);
      if (out_valid) begin
        chk("fill_drain_data", 32'(out_data), 32'(8'h10 + nout));
        nout++;
      end
    end
    chk("fill_drain_count", 32'(nout), 32'd4);

    // Backpressure: stalled output holds while grants rotate.
    do_reset();
    cycle(4'b0111, 32'h00C0_B0A0, 1'b1, 4'b0000, rq, ry);
    cycle(4'b0111, 32'h00C1_B1A1, 1'b1, 4'b0000, rq, ry);
    cycle(4'b0000, '0, 1'b1, 4'b0001, rq, ry);
    hold_d = out_data;
    hold_s = out_src;
    chk("bp_first_data", 32'(hold_d), 32'h0A0);
    g = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, '0, 1'b0, g, rq, ry);
      chk("bp_hold_data", 32'(out_data), 32'(hold_d));
      chk("bp_hold_src",  32'(out_src),  32'(hold_s));
      chk("bp_hold_req",  32'(rq),       32'h7);
      g = {g[2:0], 1'b0};
    end
    cycle(4'b0000, '0, 1'b1, 4'b0010, rq, ry);
    chk("bp_release_data", 32'(out_data), 32'h0B0);
    chk("bp_release_src",  32'(out_src),  32'd1);
    arb_on = 1'b1;
    for (int k = 0; k < 8; k++) cycle(4'b0000, '0, 1'b1, 4'b0000, rq, ry);

    // Back-to-back drain with the arbiter in the loop.
    do_reset();
    cycle(4'b1111, 32'h3020_1000, 1'b1, 4'b0000, rq, ry);
    cycle(4'b1111, 32'h3121_1101, 1'b1, 4'b0000, rq, ry);
    arb_on   = 1'b1;
    arb_last = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(4'b0000, '0, 1'b1, 4'b0000, rq, ry);
      if (out_valid) begin
        src_q.push_back(int'(out_src));
        cyc_q.push_back(k);
      end
    end
    chk("b2b_count", 32'(src_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < src_q.size(); k++) begin
      chk($sformatf("b2b_src%0d", k), 32'(src_q[k]), 32'(exp_src[k]));
      if (k > 0) chk("b2b_gap", 32'(cyc_q[k] - cyc_q[k-1]), 32'd1);
    end

    // Malformed grant: no pop, sticky error until reset.
    do_reset();
    cycle(4'b0011, 32'h0000_2211, 1'b1, 4'b0000, rq, ry);
    cycle(4'b0000, '0, 1'b1, 4'b0011, rq, ry);
    chk("bad_err_set", 32'(gnt_err), 32'd1);
    chk("bad_no_load", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) cycle(4'b0000, '0, 1'b0, 4'b0000, rq, ry);
    chk("bad_err_sticky", 32'(gnt_err), 32'd1);
    chk("bad_req_kept", 32'(rq), 32'h3);

    // Reset mid-flight with queued and output data.
    do_reset();
    cycle(4'b1111, 32'h4433_2211, 1'b1, 4'b0000, rq, ry);
    cycle(4'b1111, 32'h8877_6655, 1'b1, 4'b0000, rq, ry);
    cycle(4'b0000, '0, 1'b0, 4'b0100, rq, ry);
    chk("mid_ov_before", 32'(out_valid), 32'd1);
    do_reset();

    // Random traffic with the arbiter in the loop.
    arb_on = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      cycle(4'($urandom), 32'($urandom), ($urandom % 4) != 0, 4'b0000, rq, ry);
    end

    // Random traffic with arbitrary grant patterns, including malformed ones.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom % 16);
      if (r < 12) g = 4'(1 << (r % 4));
      else if (r < 14) g = 4'd0;
      else g = 4'($urandom);
      cycle(4'($urandom), 32'($urandom), ($urandom % 3) != 0, g, rq, ry);
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
